control_sequencer: RTL and testbench

- Moore-style control unit FSM for the Phase 2/3 datapath.
- Sits directly upstream of select-and-encode: drives Gra/Grb/Grc/Rin/Rout/BAout into it, plus every other datapath strobe.
- Decodes IR[31:27] and steps each instruction through fetch (T0-T2) and execute (T3-T7) cycles.

---
 rtl/control_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0-T2, execute T3-T7, 4-8 cycles per instruction; strobes decode combinationally from state.
// No backpressure: stop is honoured only at an instruction boundary, and HALT is left only through clear.
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            stop,
    input  logic [31:0]     IR,
    input  logic            CON_FF,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            Cout,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Read,
    output logic            Write,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            CONin,
    output logic [ALUW-1:0] alu_op,
    output logic            run,
    output logic            illegal_op
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_ALUI, C_LDI, C_LD, C_ST, C_BR, C_JR, C_NOP, C_HALT, C_ILL
    } cls_t;

    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(0);
    localparam logic [ALUW-1:0] ALU_SUB = ALUW'(1);
    localparam logic [ALUW-1:0] ALU_AND = ALUW'(2);
    localparam logic [ALUW-1:0] ALU_OR  = ALUW'(3);

    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10011);
    localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10100);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_t          state_q, state_d, end_st;
    cls_t            cls_q, cls_d, dec_cls;
    logic [ALUW-1:0] alu_q, alu_d, dec_alu;
    logic [OPW-1:0]  opcode;
    logic            ir_unused;

    assign opcode    = IR[31 -: OPW];
    assign ir_unused = ^IR[31-OPW:0];

    always_comb begin
        dec_cls = C_ILL;
        dec_alu = ALU_ADD;
        case (opcode)
            OP_ADD:  dec_cls = C_ALU;
            OP_SUB:  begin dec_cls = C_ALU;  dec_alu = ALU_SUB; end
            OP_AND:  begin dec_cls = C_ALU;  dec_alu = ALU_AND; end
            OP_OR:   begin dec_cls = C_ALU;  dec_alu = ALU_OR;  end
            OP_ADDI: dec_cls = C_ALUI;
            OP_ANDI: begin dec_cls = C_ALUI; dec_alu = ALU_AND; end
            OP_ORI:  begin dec_cls = C_ALUI; dec_alu = ALU_OR;  end
            OP_LDI:  dec_cls = C_LDI;
            OP_LD:   dec_cls = C_LD;
            OP_ST:   dec_cls = C_ST;
            OP_BR:   dec_cls = C_BR;
            OP_JR:   dec_cls = C_JR;
            OP_NOP:  dec_cls = C_NOP;
            OP_HALT: dec_cls = C_HALT;
            default: dec_cls = C_ILL;
        endcase
    end

    // The opcode class is latched on leaving T3 so later states never look at IR.
    always_comb begin
        end_st  = stop ? S_HALT : S_T0;
        state_d = state_q;
        cls_d   = cls_q;
        alu_d   = alu_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                cls_d = dec_cls;
                alu_d = dec_alu;
                case (dec_cls)
                    C_JR, C_NOP, C_ILL: state_d = end_st;
                    C_HALT:             state_d = S_HALT;
                    default:            state_d = S_T4;
                endcase
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (cls_q inside {C_LD, C_ST, C_BR}) ? S_T6 : end_st;
            S_T6:    state_d = (cls_q == C_BR) ? end_st : S_T7;
            S_T7:    state_d = end_st;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_RESET;
            cls_q   <= C_NOP;
            alu_q   <= ALU_ADD;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
        end
    end

    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        Cout = 1'b0; PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0;
        IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; CONin = 1'b0;
        alu_op     = ALU_ADD;
        illegal_op = 1'b0;
        run        = (state_q != S_HALT);
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (dec_cls)
                    C_ALU, C_ALUI:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_LDI, C_LD, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_BR:               begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    C_JR:               begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    C_ILL:              illegal_op = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls_q)
                    C_ALU: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_q; end
                    C_ALUI, C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = alu_q; end
                    C_BR:  begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls_q)
                    C_ALU, C_ALUI, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_LD, C_ST:           begin Zlowout = 1'b1; MARin = 1'b1; end
                    C_BR:                 begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls_q)
                    C_LD: begin Read = 1'b1; MDRin = 1'b1; end
                    C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    C_BR: begin Zlowout = 1'b1; PCin = CON_FF; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls_q)
                    C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: per-instruction strobe lists built from the ISA table are compared cycle by cycle.
module tb_control_sequencer;

    logic clock, clear, stop, CON_FF;
    logic [31:0] IR;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC;
    logic MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, CONin;
    logic [3:0] alu_op;
    logic run, illegal_op;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [20:0] M_GRA = 21'd1 << 0,  M_GRB = 21'd1 << 1,  M_GRC = 21'd1 << 2;
    localparam logic [20:0] M_RIN = 21'd1 << 3,  M_ROUT = 21'd1 << 4, M_BAOUT = 21'd1 << 5;
    localparam logic [20:0] M_COUT = 21'd1 << 6, M_PCOUT = 21'd1 << 7, M_PCIN = 21'd1 << 8;
    localparam logic [20:0] M_INCPC = 21'd1 << 9, M_MARIN = 21'd1 << 10, M_MDRIN = 21'd1 << 11;
    localparam logic [20:0] M_MDROUT = 21'd1 << 12, M_READ = 21'd1 << 13, M_WRITE = 21'd1 << 14;
    localparam logic [20:0] M_IRIN = 21'd1 << 15, M_YIN = 21'd1 << 16, M_ZIN = 21'd1 << 17;
    localparam logic [20:0] M_ZLOW = 21'd1 << 18, M_CONIN = 21'd1 << 19, M_ILL = 21'd1 << 20;

    localparam logic [4:0] LEGAL [14] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                          5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110,
                                          5'b10011, 5'b10100, 5'b11010, 5'b11011};

    logic [20:0] eq_s[$];
    logic [3:0]  eq_a[$];

    control_sequencer #(.OPW(5), .ALUW(4)) dut (
        .clock(clock), .clear(clear), .stop(stop), .IR(IR), .CON_FF(CON_FF),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .CONin(CONin),
        .alu_op(alu_op), .run(run), .illegal_op(illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] op);
        for (int k = 0; k < 14; k++)
            if (LEGAL[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input logic [20:0] s, input logic [3:0] a);
        eq_s.push_back(s);
        eq_a.push_back(a);
    endtask

    // Expected strobe list for one instruction, straight from the instruction table.
    task automatic gen(input logic [4:0] op, input bit con);
        eq_s.delete();
        eq_a.delete();
        push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0);
        push(M_ZLOW | M_PCIN | M_READ | M_MDRIN, 4'd0);
        push(M_MDROUT | M_IRIN, 4'd0);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                push(M_GRB | M_ROUT | M_YIN, 4'd0);
                push(M_GRC | M_ROUT | M_ZIN, 4'(op - 5'd3));
                push(M_ZLOW | M_GRA | M_RIN, 4'd0);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                push(M_GRB | M_ROUT | M_YIN, 4'd0);
                push(M_COUT | M_ZIN, (op == 5'b01100) ? 4'd0 : (op == 5'b01101) ? 4'd2 : 4'd3);
                push(M_ZLOW | M_GRA | M_RIN, 4'd0);
            end
            5'b00001: begin
                push(M_GRB | M_BAOUT | M_YIN, 4'd0);
                push(M_COUT | M_ZIN, 4'd0);
                push(M_ZLOW | M_GRA | M_RIN, 4'd0);
            end
            5'b00000, 5'b00010: begin
                push(M_GRB | M_BAOUT | M_YIN, 4'd0);
                push(M_COUT | M_ZIN, 4'd0);
                push(M_ZLOW | M_MARIN, 4'd0);
                if (op == 5'b00000) begin
                    push(M_READ | M_MDRIN, 4'd0);
                    push(M_MDROUT | M_GRA | M_RIN, 4'd0);
                end else begin
                    push(M_GRA | M_ROUT | M_MDRIN, 4'd0);
                    push(M_WRITE, 4'd0);
                end
            end
            5'b10011: begin
                push(M_GRA | M_ROUT | M_CONIN, 4'd0);
                push(M_PCOUT | M_YIN, 4'd0);
                push(M_COUT | M_ZIN, 4'd0);
                push(M_ZLOW | (con ? M_PCIN : 21'd0), 4'd0);
            end
            5'b10100: push(M_GRA | M_ROUT | M_PCIN, 4'd0);
            5'b11010, 5'b11011: push(21'd0, 4'd0);
            default: push(M_ILL, 4'd0);
        endcase
    endtask

    task automatic cyc(input logic [20:0] es, input logic [3:0] ea, input bit er, input string tag);
        logic [20:0] obs;
        obs = {illegal_op, CONin, Zlowout, Zin, Yin, IRin, Write, Read, MDRout, MDRin, MARin,
               IncPC, PCin, PCout, Cout, BAout, Rout, Rin, Grc, Grb, Gra};
        check({tag, "_strobes"}, 32'(obs), 32'(es));
        check({tag, "_alu"}, 32'(alu_op), 32'(ea));
        check({tag, "_run"}, 32'(run), 32'(er));
        check({tag, "_one_driver"},
              32'($countones({Rout, BAout, Cout, PCout, MDRout, Zlowout}) <= 1), 32'd1);
        check({tag, "_rd_wr"}, 32'(Read & Write), 32'd0);
        check({tag, "_one_gr"}, 32'($countones({Gra, Grb, Grc}) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        clear = 1'b1;
        #1;
        cyc(21'd0, 4'd0, 1'b1, "rst_async");
        @(negedge clock);
        cyc(21'd0, 4'd0, 1'b1, "rst_hold");
        clear = 1'b0;
    endtask

    // Runs one instruction from T0; abort_at >= 0 pulses clear in that step.
    task automatic run_instr(input logic [31:0] ir, input bit con, input bit stop_end, input int abort_at);
        int len;
        logic [4:0] op;
        op = ir[31:27];
        gen(op, con);
        len = eq_s.size();
        CON_FF = con;
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            cyc(eq_s[i], eq_a[i], 1'b1, $sformatf("op%b_T%0d", op, i));
            if (i == abort_at) begin
                stop = 1'b0;
                #2;
                do_reset();
                return;
            end
            if (i == 0) IR = $urandom;
            if (i == 2) IR = ir;
            stop = (i == len - 1) ? stop_end : 1'($urandom % 2);
        end
        if (stop_end || op == 5'b11011) begin
            for (int k = 0; k < 12; k++) begin
                @(negedge clock);
                cyc(21'd0, 4'd0, 1'b0, "halt");
                stop = 1'($urandom % 2);
            end
            stop = 1'b0;
            do_reset();
        end
        stop = 1'b0;
    endtask

    initial begin
        clear = 1'b0; stop = 1'b0; IR = 32'd0; CON_FF = 1'b0;
        #3;
        do_reset();
        run_instr(32'h18000000, 1'b0, 1'b0, -1);
        run_instr(32'h00800075, 1'b0, 1'b0, -1);
        run_instr(32'h10800090, 1'b0, 1'b0, -1);
        run_instr(32'h99800009, 1'b1, 1'b0, -1);
        run_instr(32'h99800009, 1'b0, 1'b0, -1);
        run_instr(32'hF8000000, 1'b0, 1'b0, -1);
        run_instr(32'h20000000, 1'b0, 1'b0, -1);
        run_instr(32'h00800075, 1'b0, 1'b0, 5);
        run_instr(32'h18000000, 1'b0, 1'b1, -1);
        run_instr(32'hD8000000, 1'b0, 1'b0, -1);
        for (int n = 0; n < 150; n++) begin
            logic [4:0] op;
            int pick;
            pick = $urandom_range(0, 14);
            if (pick < 14) begin
                op = LEGAL[pick];
            end else begin
                op = 5'($urandom);
                while (is_legal(op)) op = 5'($urandom);
            end
            run_instr({op, 27'($urandom)}, 1'($urandom % 2), ($urandom % 16) == 0,
                      (($urandom % 20) == 0) ? int'($urandom_range(0, 3)) : -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
